lab2_result_uart_tx: RTL

//   Serial transmitter for the 8-bit result byte produced by the lab datapath.

---
 rtl/lab2_result_uart_tx.sv | 119 +++++++++++
 1 files changed

// File: rtl/lab2_result_uart_tx.sv
// Serial transmitter for the lab datapath result byte: start bit, 8 data bits
// LSB first, optional even parity, one stop bit; one byte per valid/ready handshake.
module lab2_result_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             parity_bit;
    logic             bit_done;

    assign bit_done  = (baud_cnt == BAUD_LAST);
    assign ready_out = (state == IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            // Baud counter free-runs inside a frame and wraps on each bit boundary.
            if (state != IDLE) begin
                baud_cnt <= bit_done ? '0 : baud_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (valid_in) begin
                        shift_reg  <= data_in;
                        parity_bit <= ^data_in;
                        baud_cnt   <= '0;
                        bit_cnt    <= '0;
                        tx         <= 1'b0;
                        busy       <= 1'b1;
                        state      <= START;
                    end
                end

                START: begin
                    if (bit_done) begin
                        tx    <= shift_reg[0];
                        state <= DATA;
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            if (PARITY_EN) begin
                                tx    <= parity_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shift_reg[1];
                        end
                    end
                end

                PARITY: begin
                    if (bit_done) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end

                STOP: begin
                    if (bit_done) begin
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
